// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// pix_en flows into the generator; position, blanking and sync flow out.
interface vga_timing_if;
  localparam int unsigned CW = 11;

  logic          pix_en;
  logic [CW-1:0] pixel_column;
  logic [CW-1:0] pixel_row;
  logic          video_on;
  logic          video_on_dly;
  logic          horiz_sync;
  logic          vert_sync;
  logic          frame_start;

  modport master (
    input  pix_en,
    output pixel_column, pixel_row, video_on, video_on_dly,
           horiz_sync, vert_sync, frame_start
  );

  modport slave (
    output pix_en,
    input  pixel_column, pixel_row, video_on, video_on_dly,
           horiz_sync, vert_sync, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row counters, active-video flag and
// sync pulses, with syncs and video_on_dly delayed to meet the colour pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  vga_timing_if.master  vga
);

  localparam int unsigned CW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_ACTIVE + H_FP;
  localparam int unsigned H_SE    = H_SS + H_SYNC - 1;
  localparam int unsigned V_SS    = V_ACTIVE + V_FP;
  localparam int unsigned V_SE    = V_SS + V_SYNC - 1;
  localparam bit          ACT_LVL  = SYNC_POL;
  localparam bit          IDLE_LVL = ~SYNC_POL;

  logic [CW-1:0]       col_q, row_q;
  logic [CW-1:0]       col_nxt, row_nxt;
  logic                vid_nxt, hs_nxt, vs_nxt, wrap_c;
  logic                vid_q, hs_q, vs_q, frame_q;
  logic [PIPE_DLY-1:0] vid_pipe, hs_pipe, vs_pipe;

  // Next raster position and the decodes that will be aligned with it.
  always_comb begin
    col_nxt = col_q + CW'(1);
    row_nxt = row_q;
    wrap_c  = 1'b0;
    if (col_q == CW'(H_TOTAL - 1)) begin
      col_nxt = '0;
      if (row_q == CW'(V_TOTAL - 1)) begin
        row_nxt = '0;
        wrap_c  = 1'b1;
      end else begin
        row_nxt = row_q + CW'(1);
      end
    end
    vid_nxt = (col_nxt < CW'(H_ACTIVE)) && (row_nxt < CW'(V_ACTIVE));
    hs_nxt  = (col_nxt >= CW'(H_SS)) && (col_nxt <= CW'(H_SE));
    vs_nxt  = (row_nxt >= CW'(V_SS)) && (row_nxt <= CW'(V_SE));
  end

  // Sync stages hold pin levels so the outputs come straight from flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q    <= '0;
      row_q    <= '0;
      vid_q    <= 1'b0;
      hs_q     <= IDLE_LVL;
      vs_q     <= IDLE_LVL;
      frame_q  <= 1'b0;
      vid_pipe <= '0;
      hs_pipe  <= {PIPE_DLY{IDLE_LVL}};
      vs_pipe  <= {PIPE_DLY{IDLE_LVL}};
    end else begin
      frame_q <= vga.pix_en && wrap_c;
      if (vga.pix_en) begin
        col_q    <= col_nxt;
        row_q    <= row_nxt;
        vid_q    <= vid_nxt;
        hs_q     <= hs_nxt ? ACT_LVL : IDLE_LVL;
        vs_q     <= vs_nxt ? ACT_LVL : IDLE_LVL;
        vid_pipe <= (vid_pipe << 1) | PIPE_DLY'(vid_q);
        hs_pipe  <= (hs_pipe  << 1) | PIPE_DLY'(hs_q);
        vs_pipe  <= (vs_pipe  << 1) | PIPE_DLY'(vs_q);
      end
    end
  end

  assign vga.pixel_column = col_q;
  assign vga.pixel_row    = row_q;
  assign vga.video_on     = vid_q;
  assign vga.video_on_dly = vid_pipe[PIPE_DLY-1];
  assign vga.horiz_sync   = hs_pipe[PIPE_DLY-1];
  assign vga.vert_sync    = vs_pipe[PIPE_DLY-1];
  assign vga.frame_start  = frame_q;

endmodule
